// File: rtl/sequenciador_programa.sv
// Program-counter sequencer: holds pc / last_pc, resolves the next pc from the
// decoded flow operation and keeps a hardware return-address stack for
// CALL/RET. Also provides stall, halt/resume and sticky stack-error flags.
module sequenciador_programa #(
   parameter int            AW          = 32,
   parameter int            DEPTH       = 8,
   parameter logic [AW-1:0] RESET_VEC   = '0,
   parameter int            WRAP_ON_OVF = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic [2:0]                   op,
   input  logic                         cond,
   input  logic [AW-1:0]                imm_target,
   input  logic [AW-1:0]                reg_target,
   input  logic                         resume,
   input  logic                         clr_err,
   output logic [AW-1:0]                pc,
   output logic [AW-1:0]                last_pc,
   output logic [AW-1:0]                ret_top,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         halted,
   output logic                         ovf,
   output logic                         unf
);

   // Stack pointer indexes DEPTH slots; the occupancy counter needs one more code.
   localparam int            PW   = $clog2(DEPTH);
   localparam int            DW   = $clog2(DEPTH+1);
   localparam logic [DW-1:0] FULL = DW'(DEPTH);
   localparam bit            WRAP = (WRAP_ON_OVF != 0);

   localparam logic [2:0] OP_NEXT   = 3'd0;
   localparam logic [2:0] OP_JUMP   = 3'd1;
   localparam logic [2:0] OP_BRANCH = 3'd2;
   localparam logic [2:0] OP_JREG   = 3'd3;
   localparam logic [2:0] OP_CALL   = 3'd4;
   localparam logic [2:0] OP_RET    = 3'd5;
   localparam logic [2:0] OP_HALT   = 3'd6;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t         state_reg, state_next;
   logic [AW-1:0]  pc_reg, pc_next;
   logic [AW-1:0]  last_pc_reg, last_pc_next;
   logic [PW-1:0]  sp_reg, sp_next;
   logic [DW-1:0]  count_reg, count_next;
   logic           ovf_reg, ovf_next;
   logic           unf_reg, unf_next;

   logic [AW-1:0]  stack_mem [DEPTH];

   logic [AW-1:0]  pc_inc;
   logic [PW-1:0]  sp_m1;
   logic [AW-1:0]  top_entry;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           ovf_set;
   logic           unf_set;

   // sp_reg points at the next free slot; the newest entry sits just below it.
   // When the stack is full in circular mode, sp_reg also points at the oldest
   // entry, so a push there overwrites exactly the oldest return address.
   assign pc_inc    = pc_reg + AW'(1);
   assign sp_m1     = sp_reg - PW'(1);
   assign top_entry = stack_mem[sp_m1];
   assign full      = (count_reg == FULL);
   assign empty     = (count_reg == '0);

   // Next-state, next-pc and stack-control decode.
   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      last_pc_next = last_pc_reg;
      push         = 1'b0;
      pop          = 1'b0;
      ovf_set      = 1'b0;
      unf_set      = 1'b0;

      if (!stall) begin
         case (state_reg)
            ST_RUN: begin
               last_pc_next = pc_reg;
               case (op)
                  OP_NEXT:   pc_next = pc_inc;
                  OP_JUMP:   pc_next = imm_target;
                  OP_BRANCH: pc_next = cond ? imm_target : pc_inc;
                  OP_JREG:   pc_next = reg_target;
                  OP_CALL: begin
                     if (full && !WRAP) begin
                        // Refused call: fall through to the next instruction.
                        pc_next = pc_inc;
                        ovf_set = 1'b1;
                     end else begin
                        push    = 1'b1;
                        pc_next = imm_target;
                        ovf_set = full;
                     end
                  end
                  OP_RET: begin
                     if (empty) begin
                        pc_next = pc_inc;
                        unf_set = 1'b1;
                     end else begin
                        pop     = 1'b1;
                        pc_next = top_entry;
                     end
                  end
                  OP_HALT: begin
                     // pc parks on the HALT instruction itself.
                     pc_next    = pc_reg;
                     state_next = ST_HALTED;
                  end
                  default:   pc_next = pc_inc;
               endcase
            end
            ST_HALTED: begin
               if (resume) begin
                  state_next = ST_RUN;
               end
            end
            default: state_next = ST_RUN;
         endcase
      end
   end

   // Stack pointer and occupancy bookkeeping.
   always_comb begin
      sp_next    = sp_reg;
      count_next = count_reg;
      if (push) begin
         sp_next    = sp_reg + PW'(1);
         count_next = full ? count_reg : count_reg + DW'(1);
      end else if (pop) begin
         sp_next    = sp_m1;
         count_next = count_reg - DW'(1);
      end
   end

   // Sticky error flags: a set on the same edge takes priority over clr_err.
   always_comb begin
      ovf_next = ovf_set | (ovf_reg & ~clr_err);
      unf_next = unf_set | (unf_reg & ~clr_err);
   end

   // Control and pc registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_RUN;
         pc_reg      <= RESET_VEC;
         last_pc_reg <= RESET_VEC;
         sp_reg      <= '0;
         count_reg   <= '0;
         ovf_reg     <= 1'b0;
         unf_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         last_pc_reg <= last_pc_next;
         sp_reg      <= sp_next;
         count_reg   <= count_next;
         ovf_reg     <= ovf_next;
         unf_reg     <= unf_next;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[sp_reg] <= pc_inc;
      end
   end

   assign pc      = pc_reg;
   assign last_pc = last_pc_reg;
   assign ret_top = empty ? '0 : top_entry;
   assign depth   = count_reg;
   assign halted  = (state_reg == ST_HALTED);
   assign ovf     = ovf_reg;
   assign unf     = unf_reg;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Bench for sequenciador_programa: two instances (refusing and circular
// overflow policies) share one stimulus stream and are compared against a
// per-instance behavioural model, plus a table of hand-derived vectors and
// hand-written multi-cycle sequences.
module tb_sequenciador_programa;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        cond = 1'b0;
   logic [31:0] imm_target = '0;
   logic [31:0] reg_target = '0;
   logic        resume = 1'b0;
   logic        clr_err = 1'b0;

   logic [31:0] pc_o    [2];
   logic [31:0] last_o  [2];
   logic [31:0] top_o   [2];
   logic [3:0]  depth_o [2];
   logic        halt_o  [2];
   logic        ovf_o   [2];
   logic        unf_o   [2];

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   // Behavioural model state, index 0 = refusing, 1 = circular.
   logic [31:0] m_pc   [2];
   logic [31:0] m_last [2];
   logic        m_halt [2];
   logic        m_ovf  [2];
   logic        m_unf  [2];
   logic [31:0] m_stk  [2][8];
   int          m_cnt  [2];

   localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, BR = 3'd2, JR = 3'd3,
                          CALL = 3'd4, RET = 3'd5, HALT = 3'd6;

   sequenciador_programa #(.AW(32), .DEPTH(8), .RESET_VEC(32'h0), .WRAP_ON_OVF(0)) u0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .cond(cond),
      .imm_target(imm_target), .reg_target(reg_target), .resume(resume), .clr_err(clr_err),
      .pc(pc_o[0]), .last_pc(last_o[0]), .ret_top(top_o[0]), .depth(depth_o[0]),
      .halted(halt_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0])
   );

   sequenciador_programa #(.AW(32), .DEPTH(8), .RESET_VEC(32'h0), .WRAP_ON_OVF(1)) u1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .cond(cond),
      .imm_target(imm_target), .reg_target(reg_target), .resume(resume), .clr_err(clr_err),
      .pc(pc_o[1]), .last_pc(last_o[1]), .ret_top(top_o[1]), .depth(depth_o[1]),
      .halted(halt_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1])
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (txn %0d)", nm, act, exp, n_txn);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = '0; m_last[k] = '0; m_halt[k] = 1'b0;
         m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_cnt[k] = 0;
      end
   endtask

   // One clock of the behavioural model, using the inputs as applied.
   task automatic model_step(input int k);
      logic [31:0] inc;
      logic sov, sun;
      sov = 1'b0; sun = 1'b0;
      inc = m_pc[k] + 32'd1;
      if (!stall) begin
         if (m_halt[k]) begin
            if (resume) m_halt[k] = 1'b0;
         end else begin
            m_last[k] = m_pc[k];
            case (op)
               JMP: m_pc[k] = imm_target;
               BR:  m_pc[k] = cond ? imm_target : inc;
               JR:  m_pc[k] = reg_target;
               CALL: begin
                  if (m_cnt[k] == 8 && k == 0) begin
                     m_pc[k] = inc; sov = 1'b1;
                  end else begin
                     if (m_cnt[k] == 8) begin
                        for (int s = 0; s < 7; s++) m_stk[k][s] = m_stk[k][s+1];
                        m_cnt[k] = 7; sov = 1'b1;
                     end
                     m_stk[k][m_cnt[k]] = inc;
                     m_cnt[k]++;
                     m_pc[k] = imm_target;
                  end
               end
               RET: begin
                  if (m_cnt[k] == 0) begin
                     m_pc[k] = inc; sun = 1'b1;
                  end else begin
                     m_cnt[k]--;
                     m_pc[k] = m_stk[k][m_cnt[k]];
                  end
               end
               HALT: m_halt[k] = 1'b1;
               default: m_pc[k] = inc;
            endcase
         end
      end
      m_ovf[k] = sov | (m_ovf[k] & ~clr_err);
      m_unf[k] = sun | (m_unf[k] & ~clr_err);
   endtask

   task automatic compare_model();
      logic [31:0] et;
      for (int k = 0; k < 2; k++) begin
         et = (m_cnt[k] == 0) ? 32'h0 : m_stk[k][m_cnt[k]-1];
         chk($sformatf("model_pc%0d", k),    pc_o[k],              m_pc[k]);
         chk($sformatf("model_last%0d", k),  last_o[k],            m_last[k]);
         chk($sformatf("model_top%0d", k),   top_o[k],             et);
         chk($sformatf("model_depth%0d", k), 32'(depth_o[k]),      32'(m_cnt[k]));
         chk($sformatf("model_halt%0d", k),  32'(halt_o[k]),       32'(m_halt[k]));
         chk($sformatf("model_ovf%0d", k),   32'(ovf_o[k]),        32'(m_ovf[k]));
         chk($sformatf("model_unf%0d", k),   32'(unf_o[k]),        32'(m_unf[k]));
      end
   endtask

   // Apply one cycle of inputs, clock, and compare both instances with the model.
   task automatic step(input logic [2:0] o, input logic c, input logic [31:0] im,
                       input logic [31:0] rg, input logic st, input logic rs, input logic cl);
      op = o; cond = c; imm_target = im; reg_target = rg;
      stall = st; resume = rs; clr_err = cl;
      @(posedge clk);
      #1;
      n_txn++;
      model_step(0);
      model_step(1);
      $display("txn %0d op=%0d stall=%0b pc=%h/%h depth=%0d/%0d", n_txn, o, st,
               pc_o[0], pc_o[1], depth_o[0], depth_o[1]);
      compare_model();
   endtask

   // Asynchronous reset: outputs must be at reset values before any clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_pc0_async", pc_o[0], 32'h0);
      chk("rst_pc1_async", pc_o[1], 32'h0);
      compare_model();
      op = NXT; stall = 1'b0; resume = 1'b0; clr_err = 1'b0; cond = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic        cond;
      logic [31:0] imm;
      logic [31:0] regt;
      logic        clr;
      logic [31:0] exp_pc;
      logic [31:0] exp_last;
      logic [31:0] exp_top;
      int          exp_depth;
      logic        exp_ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [2:0] o, logic c, logic [31:0] im, logic [31:0] rg, logic cl,
                               logic [31:0] epc, logic [31:0] el, logic [31:0] et, int ed, logic eo);
      vec_t v;
      v.op = o; v.cond = c; v.imm = im; v.regt = rg; v.clr = cl;
      v.exp_pc = epc; v.exp_last = el; v.exp_top = et; v.exp_depth = ed; v.exp_ovf = eo;
      return v;
   endfunction

   initial begin
      logic [31:0] hold_pc;
      logic [3:0]  hold_depth;
      logic [2:0]  ro;
      int          r;

      // Expectations for the refusing-policy instance, starting from reset.
      tbl.push_back(mk(NXT,  0, 32'h0,   32'h0,    0, 32'h1,    32'h0,    32'h0,   0, 0));
      tbl.push_back(mk(NXT,  0, 32'h0,   32'h0,    0, 32'h2,    32'h1,    32'h0,   0, 0));
      tbl.push_back(mk(NXT,  0, 32'h0,   32'h0,    0, 32'h3,    32'h2,    32'h0,   0, 0));
      tbl.push_back(mk(JMP,  0, 32'h5,   32'h0,    0, 32'h5,    32'h3,    32'h0,   0, 0));
      tbl.push_back(mk(BR,   0, 32'h40,  32'h0,    0, 32'h6,    32'h5,    32'h0,   0, 0));
      tbl.push_back(mk(BR,   1, 32'h40,  32'h0,    0, 32'h40,   32'h6,    32'h0,   0, 0));
      tbl.push_back(mk(JR,   1, 32'h77,  32'h1234, 0, 32'h1234, 32'h40,   32'h0,   0, 0));
      tbl.push_back(mk(JMP,  0, 32'h10,  32'h0,    0, 32'h10,   32'h1234, 32'h0,   0, 0));
      tbl.push_back(mk(CALL, 0, 32'h100, 32'h0,    0, 32'h100,  32'h10,   32'h11,  1, 0));
      tbl.push_back(mk(CALL, 0, 32'h200, 32'h0,    0, 32'h200,  32'h100,  32'h101, 2, 0));
      tbl.push_back(mk(RET,  0, 32'h0,   32'h0,    0, 32'h101,  32'h200,  32'h11,  1, 0));
      tbl.push_back(mk(RET,  0, 32'h0,   32'h0,    0, 32'h11,   32'h101,  32'h0,   0, 0));
      tbl.push_back(mk(JMP,  0, 32'h80,  32'h0,    0, 32'h80,   32'h11,   32'h0,   0, 0));
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(CALL, 0, 32'h80, 32'h0, 0, 32'h80, 32'h80, 32'h81, i, 0));
      tbl.push_back(mk(CALL, 0, 32'h80,  32'h0,    0, 32'h81,   32'h80,   32'h81,  8, 1));
      tbl.push_back(mk(NXT,  0, 32'h0,   32'h0,    1, 32'h82,   32'h81,   32'h81,  8, 0));

      #1;
      do_reset();

      // Table-driven vectors.
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].op, tbl[i].cond, tbl[i].imm, tbl[i].regt, 1'b0, 1'b0, tbl[i].clr);
         chk($sformatf("tbl%0d_pc", i),    pc_o[0],          tbl[i].exp_pc);
         chk($sformatf("tbl%0d_last", i),  last_o[0],        tbl[i].exp_last);
         chk($sformatf("tbl%0d_top", i),   top_o[0],         tbl[i].exp_top);
         chk($sformatf("tbl%0d_depth", i), 32'(depth_o[0]),  32'(tbl[i].exp_depth));
         chk($sformatf("tbl%0d_ovf", i),   32'(ovf_o[0]),    32'(tbl[i].exp_ovf));
      end

      // Nine distinct CALLs: circular instance keeps the eight newest returns.
      do_reset();
      for (int i = 0; i < 9; i++)
         step(CALL, 0, 32'h10 * (i + 1), 32'h0, 0, 0, 0);
      chk("wrap_depth1", 32'(depth_o[1]), 32'd8);
      chk("wrap_ovf1",   32'(ovf_o[1]),   32'd1);
      chk("wrap_pc1",    pc_o[1],         32'h90);
      chk("refuse_pc0",  pc_o[0],         32'h81);
      for (int j = 0; j < 8; j++) begin
         step(RET, 0, 32'h0, 32'h0, 0, 0, 0);
         chk($sformatf("wrap_ret%0d", j), pc_o[1], 32'h10 * (8 - j) + 32'h1);
      end
      chk("wrap_empty1", 32'(depth_o[1]), 32'd0);
      chk("wrap_ovf1b",  32'(ovf_o[1]),   32'd1);
      chk("wrap_unf1a",  32'(unf_o[1]),   32'd0);
      step(RET, 0, 32'h0, 32'h0, 0, 0, 0);
      chk("wrap_unf1",   32'(unf_o[1]),   32'd1);
      chk("wrap_unfpc1", pc_o[1],         32'h12);

      // HALT holds pc despite CALLs, resume returns to RUN.
      step(JMP, 0, 32'h20, 32'h0, 0, 0, 0);
      step(HALT, 0, 32'h0, 32'h0, 0, 0, 0);
      chk("halt_flag", 32'(halt_o[0]), 32'd1);
      chk("halt_pc",   pc_o[0],        32'h20);
      hold_depth = depth_o[0];
      for (int i = 0; i < 5; i++) begin
         step(CALL, 0, 32'h999, 32'h0, 0, 0, 0);
         chk($sformatf("halt_hold_pc%0d", i), pc_o[0], 32'h20);
         chk($sformatf("halt_hold_d%0d", i),  32'(depth_o[0]), 32'(hold_depth));
      end
      step(NXT, 0, 32'h0, 32'h0, 0, 1, 0);
      chk("resume_flag", 32'(halt_o[0]), 32'd0);
      chk("resume_pc",   pc_o[0],        32'h20);
      step(NXT, 0, 32'h0, 32'h0, 0, 0, 0);
      chk("resume_next", pc_o[0],        32'h21);

      // Stall freezes everything; clr_err still acts under stall.
      hold_pc = pc_o[0];
      step(CALL, 0, 32'h300, 32'h0, 1, 0, 0);
      chk("stall_pc",    pc_o[0],         hold_pc);
      chk("stall_depth", 32'(depth_o[0]), 32'd0);
      chk("stall_ovf",   32'(ovf_o[0]),   32'd1);
      step(CALL, 0, 32'h300, 32'h0, 1, 0, 1);
      chk("stall_clr_ovf", 32'(ovf_o[0]), 32'd0);
      chk("stall_clr_unf", 32'(unf_o[0]), 32'd0);
      chk("stall_clr_pc",  pc_o[0],       hold_pc);

      // Return address wraps modulo 2^32.
      step(JMP, 0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
      step(NXT, 0, 32'h0, 32'h0, 0, 0, 0);
      chk("pc_wrap", pc_o[0], 32'h0);
      step(JMP, 0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
      step(CALL, 0, 32'h5, 32'h0, 0, 0, 0);
      chk("push_wrap_top",   top_o[0],        32'h0);
      chk("push_wrap_depth", 32'(depth_o[0]), 32'd1);
      step(RET, 0, 32'h0, 32'h0, 0, 0, 0);
      chk("pop_wrap_pc", pc_o[0], 32'h0);

      // Reset dropped while halted and stalled acts without a clock edge.
      step(JMP, 0, 32'h33, 32'h0, 0, 0, 0);
      step(HALT, 0, 32'h0, 32'h0, 0, 0, 0);
      step(NXT, 0, 32'h0, 32'h0, 1, 0, 0);
      do_reset();
      chk("rst_halt0", 32'(halt_o[0]), 32'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         if (r < 4)        ro = NXT;
         else if (r == 4)  ro = JMP;
         else if (r < 7)   ro = BR;
         else if (r == 7)  ro = JR;
         else if (r < 11)  ro = CALL;
         else if (r < 14)  ro = RET;
         else if (r == 14) ro = HALT;
         else              ro = 3'd7;
         hold_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                : 32'($urandom_range(0, 255));
         step(ro, 1'($urandom_range(0, 1)), hold_pc, $urandom,
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
